// File: rtl/zbt_song_sequencer.sv
// ZBT transport controller: play/record/pause/stop sequencing,
// word addressing inside each song region and per-song lengths.
module zbt_song_sequencer #(
  parameter int WORD_W = 16,
  parameter int SPW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              play_req,
  input  logic              record_req,
  input  logic              stop_req,
  input  logic              pause_toggle,
  input  logic [3:0]        song_sel,
  output logic              start_song,
  output logic [3:0]        song_choice,
  output logic              record_mode,
  output logic              pause_song,
  output logic              song_done,
  output logic [WORD_W+2:0] addr,
  output logic              busy
);

  localparam int SW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SPW - 1);
  localparam logic [WORD_W-1:0] WMAX = '1;

  typedef enum logic [2:0] {
    IDLE, ARM, RUN, PAUSED, DONE
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] word, word_n;
  logic [SW-1:0]     samp, samp_n;
  logic [3:0]        choice_n;
  logic              rec_n;
  logic              len_we;
  logic [WORD_W-1:0] len_val;
  logic [WORD_W-1:0] len_q [16];
  logic [WORD_W-1:0] cur_len;

  assign cur_len = len_q[song_choice];
  assign addr    = {song_choice[2:0], word};

  always_comb begin
    state_n  = state;
    word_n   = word;
    samp_n   = samp;
    choice_n = song_choice;
    rec_n    = record_mode;
    len_we   = 1'b0;
    len_val  = word;
    unique case (state)
      IDLE, DONE: begin
        if (stop_req) begin
          state_n = IDLE;
        end else if (record_req || play_req) begin
          state_n  = ARM;
          choice_n = song_sel;
          rec_n    = record_req;
          word_n   = '0;
          samp_n   = '0;
        end
      end
      ARM: begin
        if (!record_mode && cur_len == '0)
          state_n = DONE;
        else
          state_n = RUN;
      end
      RUN, PAUSED: begin
        if (stop_req) begin
          len_we  = record_mode;
          state_n = DONE;
        end else if (pause_toggle) begin
          state_n = (state == RUN) ? PAUSED : RUN;
        end else if (state == RUN && ready) begin
          if (samp == SLAST) begin
            samp_n = '0;
            // a full region ends the take instead of wrapping
            if (record_mode && word == WMAX) begin
              len_we  = 1'b1;
              len_val = WMAX;
              state_n = DONE;
            end else begin
              word_n = word + 1'b1;
              if (!record_mode && word_n == cur_len)
                state_n = DONE;
            end
          end else begin
            samp_n = samp + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      word        <= '0;
      samp        <= '0;
      song_choice <= '0;
      record_mode <= 1'b0;
      start_song  <= 1'b0;
      pause_song  <= 1'b0;
      song_done   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      word        <= word_n;
      samp        <= samp_n;
      song_choice <= choice_n;
      record_mode <= rec_n;
      start_song  <= (state_n == ARM);
      pause_song  <= (state_n == PAUSED);
      song_done   <= (state_n == DONE);
      busy        <= (state_n == ARM) ||
                     (state_n == RUN) ||
                     (state_n == PAUSED);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        len_q[i] <= '0;
    end else if (len_we) begin
      len_q[song_choice] <= len_val;
    end
  end

endmodule

// File: tb/tb_zbt_song_sequencer.sv
// Bench for zbt_song_sequencer: directed transport scenarios then
// random requests, two widths checked against a strobe-count model.
module tb_zbt_song_sequencer;

  localparam int SPW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready = 1'b0;
  logic play_req = 1'b0;
  logic record_req = 1'b0;
  logic stop_req = 1'b0;
  logic pause_toggle = 1'b0;
  logic [3:0] song_sel = 4'h0;

  logic        start16, rec16, pause16, done16, busy16;
  logic [3:0]  choice16;
  logic [18:0] addr16;
  logic        start4, rec4, pause4, done4, busy4;
  logic [3:0]  choice4;
  logic [6:0]  addr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zbt_song_sequencer #(.WORD_W(16), .SPW(SPW)) dut16 (
    .clk(clk), .reset(reset), .ready(ready),
    .play_req(play_req), .record_req(record_req),
    .stop_req(stop_req), .pause_toggle(pause_toggle),
    .song_sel(song_sel), .start_song(start16),
    .song_choice(choice16), .record_mode(rec16),
    .pause_song(pause16), .song_done(done16),
    .addr(addr16), .busy(busy16)
  );

  zbt_song_sequencer #(.WORD_W(4), .SPW(SPW)) dut4 (
    .clk(clk), .reset(reset), .ready(ready),
    .play_req(play_req), .record_req(record_req),
    .stop_req(stop_req), .pause_toggle(pause_toggle),
    .song_sel(song_sel), .start_song(start4),
    .song_choice(choice4), .record_mode(rec4),
    .pause_song(pause4), .song_done(done4),
    .addr(addr4), .busy(busy4)
  );

  // model: phase 0 idle,1 arm,2 run,3 paused,4 done
  int wv   [2] = '{16, 4};
  int ph   [2];
  int mrec [2];
  int msong[2];
  int n    [2];
  int mword[2];
  int lenm [2][16];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic latch(input int k);
    mrec[k]  = int'(record_req);
    msong[k] = int'(song_sel);
    n[k]     = 0;
    mword[k] = 0;
    ph[k]    = 1;
  endtask

  task automatic mstep(input int k);
    int maxw;
    maxw = (1 << wv[k]) - 1;
    if (!reset) begin
      ph[k] = 0; mrec[k] = 0; msong[k] = 0;
      n[k] = 0; mword[k] = 0;
      for (int i = 0; i < 16; i++) lenm[k][i] = 0;
    end else begin
      case (ph[k])
        0: if (!stop_req && (record_req || play_req)) latch(k);
        1: ph[k] = (!mrec[k] && lenm[k][msong[k]] == 0) ? 4 : 2;
        2, 3: begin
          if (stop_req) begin
            if (mrec[k] != 0) lenm[k][msong[k]] = mword[k];
            ph[k] = 4;
          end else if (pause_toggle) begin
            ph[k] = (ph[k] == 2) ? 3 : 2;
          end else if (ph[k] == 2 && ready) begin
            n[k]++;
            if (n[k] % SPW == 0) begin
              if (mrec[k] != 0 && n[k] / SPW > maxw) begin
                lenm[k][msong[k]] = maxw;
                ph[k] = 4;
              end else begin
                mword[k] = n[k] / SPW;
                if (mrec[k] == 0 && mword[k] == lenm[k][msong[k]])
                  ph[k] = 4;
              end
            end
          end
        end
        default: begin
          if (stop_req) ph[k] = 0;
          else if (record_req || play_req) latch(k);
        end
      endcase
    end
  endtask

  function automatic logic [31:0] exp_ctl(input int k);
    logic [31:0] v;
    v = '0;
    v[8] = (ph[k] == 1);
    v[7] = (ph[k] == 3);
    v[6] = (ph[k] == 4);
    v[5] = (ph[k] >= 1 && ph[k] <= 3);
    v[4] = (mrec[k] != 0);
    v[3:0] = 4'(msong[k]);
    return v;
  endfunction

  function automatic logic [31:0] exp_addr(input int k);
    return 32'(((msong[k] & 7) << wv[k]) | mword[k]);
  endfunction

  task automatic check_all();
    chk("ctl16", {23'b0, start16, pause16, done16, busy16,
                  rec16, choice16}, exp_ctl(0));
    chk("addr16", {13'b0, addr16}, exp_addr(0));
    chk("ctl4", {23'b0, start4, pause4, done4, busy4,
                 rec4, choice4}, exp_ctl(1));
    chk("addr4", {25'b0, addr4}, exp_addr(1));
  endtask

  task automatic cyc(input logic rs, input logic st,
                     input logic rq, input logic pq,
                     input logic pt, input logic rd,
                     input logic [3:0] sel);
    reset = rs; stop_req = st; record_req = rq;
    play_req = pq; pause_toggle = pt; ready = rd;
    song_sel = sel;
    mstep(0);
    mstep(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, song_sel);
  endtask

  task automatic strobe();
    cyc(1, 0, 0, 0, 0, 1, song_sel);
    idle();
  endtask

  initial begin
    // reset and empty-song playback
    cyc(0, 0, 0, 0, 0, 0, 4'h0);
    cyc(0, 0, 0, 0, 0, 0, 4'h0);
    chk("rst_addr", {13'b0, addr16}, 32'h0);
    chk("rst_outs", {27'b0, start16, pause16, done16, busy16, rec16}, 32'h0);
    cyc(1, 0, 0, 1, 0, 0, 4'h5);
    chk("arm_start", {31'b0, start16}, 32'h1);
    idle();
    chk("empty_done", {31'b0, done16}, 32'h1);

    // record song A for nine strobes
    cyc(1, 0, 1, 0, 0, 0, 4'hA);
    chk("rec_start", {31'b0, start16}, 32'h1);
    chk("rec_addr0", {13'b0, addr16}, 32'h20000);
    idle();
    chk("start_pulse", {31'b0, start16}, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      strobe();
      if (i % 3 == 0)
        chk("rec_addr", {13'b0, addr16}, 32'(32'h20000 + i / 3));
    end
    cyc(1, 1, 0, 0, 0, 0, 4'hA);
    chk("rec_stop", {31'b0, done16}, 32'h1);

    // play it back: ends at word 3 and stays there
    cyc(1, 0, 0, 1, 0, 0, 4'hA);
    idle();
    for (int i = 0; i < 9; i++) strobe();
    chk("play_done", {31'b0, done16}, 32'h1);
    chk("play_addr", {13'b0, addr16}, 32'h20003);
    for (int i = 0; i < 3; i++) strobe();
    chk("play_hold", {13'b0, addr16}, 32'h20003);

    // pause in the middle of a word
    cyc(1, 0, 1, 0, 0, 0, 4'h3);
    idle();
    for (int i = 0; i < 4; i++) strobe();
    cyc(1, 0, 0, 0, 1, 0, 4'h3);
    chk("paused", {31'b0, pause16}, 32'h1);
    for (int i = 0; i < 5; i++) strobe();
    chk("pause_addr", {13'b0, addr16}, 32'h30001);
    cyc(1, 0, 0, 0, 1, 0, 4'h3);
    chk("resumed", {31'b0, pause16}, 32'h0);
    strobe();
    strobe();
    chk("resume_addr", {13'b0, addr16}, 32'h30002);
    cyc(1, 1, 0, 0, 0, 0, 4'h3);

    // narrow instance fills its region and stops at word 15
    cyc(1, 0, 1, 0, 0, 0, 4'h2);
    idle();
    for (int i = 0; i < 60; i++) strobe();
    chk("full_done4", {31'b0, done4}, 32'h1);
    chk("full_addr4", {25'b0, addr4}, 32'h2F);
    chk("full_addr16", {13'b0, addr16}, 32'h20014);
    cyc(1, 1, 0, 0, 0, 0, 4'h2);
    cyc(1, 0, 0, 1, 0, 0, 4'h2);
    idle();
    for (int i = 0; i < 45; i++) strobe();
    chk("full_play4", {25'b0, done4, addr4}, 32'hAF);
    cyc(1, 1, 0, 0, 0, 0, 4'h2);
    cyc(1, 1, 0, 0, 0, 0, 4'h2);

    // stop coincident with the word-completing strobe
    cyc(1, 0, 1, 0, 0, 0, 4'h6);
    idle();
    strobe();
    strobe();
    cyc(1, 1, 0, 0, 0, 1, 4'h6);
    chk("stop_rdy", {12'b0, done16, addr16}, 32'hE0000);
    cyc(1, 1, 0, 0, 0, 0, 4'h6);
    cyc(1, 0, 0, 1, 0, 0, 4'h6);
    idle();
    chk("stop_len0", {31'b0, done16}, 32'h1);

    // reset in the middle of playback clears the table
    cyc(1, 0, 0, 1, 0, 0, 4'hA);
    idle();
    for (int i = 0; i < 4; i++) strobe();
    cyc(0, 0, 0, 0, 0, 0, 4'hA);
    chk("mid_rst", {12'b0, busy16, addr16}, 32'h0);
    cyc(1, 0, 0, 1, 0, 0, 4'hA);
    idle();
    chk("rst_table", {31'b0, done16}, 32'h1);

    // random requests against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic rs;
      r  = $urandom_range(0, 99);
      rs = ($urandom_range(0, 499) != 0);
      cyc(rs, r < 3, r >= 3 && r < 7, r >= 7 && r < 12,
          r >= 12 && r < 15, $urandom_range(0, 2) == 0,
          4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
